eq_cfg_ctrl: RTL and testbench

Configuration controller between the I2C slave register interface and the equalizer filter bank.
- Holds the shadow register file written over I2C.
- Serves read-back data to the I2C slave.
- On a commit request, waits for an audio frame boundary, then streams the band gains to the filter bank one band at a time over a valid/ready handshake.
- Coefficients therefore never change mid-sample.

---
 rtl/eq_cfg_ctrl_if.sv | 35 +++
 rtl/eq_cfg_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_eq_cfg_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_cfg_ctrl_if.sv
// Register-bus and filter-bank handshake bundle for eq_cfg_ctrl.
// slave = controller side, master = I2C slave / filter bank / bench side.
interface eq_cfg_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              sample_tick;
    logic              cfg_valid;
    logic [3:0]        cfg_band;
    logic [DATA_W-1:0] cfg_gain;
    logic              cfg_ready;
    logic              bypass;
    logic              mute;
    logic              busy;
    logic              commit_done;
    logic              err_addr;
    logic              err_timeout;

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, sample_tick, cfg_ready,
        output rd_data, cfg_valid, cfg_band, cfg_gain, bypass, mute, busy,
               commit_done, err_addr, err_timeout
    );

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, sample_tick, cfg_ready,
        input  rd_data, cfg_valid, cfg_band, cfg_gain, bypass, mute, busy,
               commit_done, err_addr, err_timeout
    );
endinterface

// File: rtl/eq_cfg_ctrl.sv
// Equalizer configuration controller: shadow register file plus frame-aligned band-gain streaming.
// Optional handshake watchdog enabled by defining EQ_CFG_TIMEOUT_EN.
module eq_cfg_ctrl #(
    parameter int                NUM_REGS  = 30,
    parameter int                NUM_BANDS = 10,
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] GAIN_MAX  = 8'd48
`ifdef EQ_CFG_TIMEOUT_EN
    ,
    parameter int                TIMEOUT_CYC = 255
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    eq_cfg_ctrl_if.slave bus
);

    localparam logic [ADDR_W:0] LP_NREGS  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] LP_NBANDS = (ADDR_W+1)'(NUM_BANDS);
    localparam logic [3:0]      LP_LAST   = 4'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_SEND      = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_regs      [NUM_REGS];
    logic [DATA_W-1:0] w_regs_next [NUM_REGS];
    logic [DATA_W-1:0] r_stage     [NUM_BANDS];
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic              r_pend;
    logic              w_pend_next;
    logic              w_load;
    logic [DATA_W-1:0] w_gain_next;
    logic [ADDR_W:0]   w_wr_addr_x;
    logic [ADDR_W:0]   w_rd_addr_x;
    logic              w_wr_ok;
    logic              w_wr_bad;
    logic              w_commit;
    logic              w_acc;

    logic              r_cfg_valid;
    logic [3:0]        r_cfg_band;
    logic [DATA_W-1:0] r_cfg_gain;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_busy;
    logic              r_commit_done;
    logic              r_err_addr;

`ifdef EQ_CFG_TIMEOUT_EN
    localparam logic [7:0] LP_WDOG_LIM = 8'(TIMEOUT_CYC - 1);
    logic       r_wdog;
    logic [7:0] r_wdog_cnt;
    logic       w_abort;
`endif

    assign w_wr_addr_x = {1'b0, bus.wr_addr};
    assign w_rd_addr_x = {1'b0, bus.rd_addr};
    assign w_wr_ok     = bus.wr_en & (w_wr_addr_x < LP_NREGS);
    assign w_wr_bad    = bus.wr_en & ~(w_wr_addr_x < LP_NREGS);
    assign w_commit    = w_wr_ok & (w_wr_addr_x == {(ADDR_W+1){1'b0}}) & bus.wr_data[0];
    assign w_acc       = r_cfg_valid & bus.cfg_ready;

    // Shadow register update: commit bit never stored, band gains saturate at GAIN_MAX.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_regs_next[i] = r_regs[i];
        end
        if (w_wr_ok) begin
            if (w_wr_addr_x == {(ADDR_W+1){1'b0}}) begin
                w_regs_next[bus.wr_addr] = {bus.wr_data[DATA_W-1:1], 1'b0};
            end else if (w_wr_addr_x <= LP_NBANDS) begin
                w_regs_next[bus.wr_addr] = (bus.wr_data > GAIN_MAX) ? GAIN_MAX : bus.wr_data;
            end else begin
                w_regs_next[bus.wr_addr] = bus.wr_data;
            end
        end else begin
            w_regs_next[0] = r_regs[0];
        end
    end

    // Next-state logic; a commit seen outside IDLE is folded into the single pending flag.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pend_next  = r_pend | w_commit;
        w_gain_next  = r_cfg_gain;
        w_load       = 1'b0;
`ifdef EQ_CFG_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_pend_next = 1'b0;
                if (w_commit || r_pend) begin
                    w_state_next = ST_WAIT_TICK;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_TICK: begin
                if (bus.sample_tick) begin
                    w_state_next = ST_SEND;
                    w_cnt_next   = 4'd0;
                    w_gain_next  = w_regs_next[1];
                    w_load       = 1'b1;
                end else begin
                    w_state_next = ST_WAIT_TICK;
                end
            end
            ST_SEND: begin
                if (w_acc) begin
                    if (r_cnt == LP_LAST) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_cnt_next  = r_cnt + 4'd1;
                        w_gain_next = r_stage[r_cnt + 4'd1];
                    end
                end
`ifdef EQ_CFG_TIMEOUT_EN
                else if (r_wdog && (r_wdog_cnt == LP_WDOG_LIM)) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end
`endif
                else begin
                    w_state_next = ST_SEND;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, register file, snapshot and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_pend        <= 1'b0;
            r_cfg_valid   <= 1'b0;
            r_cfg_band    <= 4'd0;
            r_cfg_gain    <= {DATA_W{1'b0}};
            r_rd_data     <= {DATA_W{1'b0}};
            r_busy        <= 1'b0;
            r_commit_done <= 1'b0;
            r_err_addr    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_stage[b] <= {DATA_W{1'b0}};
            end
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_pend        <= w_pend_next;
            r_cfg_valid   <= (w_state_next == ST_SEND);
            r_cfg_band    <= w_cnt_next;
            r_cfg_gain    <= w_gain_next;
            r_busy        <= (w_state_next != ST_IDLE);
            r_commit_done <= (w_state_next == ST_DONE);
            r_err_addr    <= w_wr_bad;
            r_rd_data     <= (w_rd_addr_x < LP_NREGS) ? r_regs[bus.rd_addr] : {DATA_W{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= w_regs_next[i];
            end
            // Snapshot sees a gain write landing on the tick cycle itself.
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_stage[b] <= w_load ? w_regs_next[b+1] : r_stage[b];
            end
        end
    end

`ifdef EQ_CFG_TIMEOUT_EN
    logic r_err_timeout;

    // Watchdog counts stalled SEND cycles; restarts on every accepted band.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog        <= 1'b0;
            r_wdog_cnt    <= 8'd0;
            r_err_timeout <= 1'b0;
        end else begin
            r_wdog        <= (w_state_next == ST_SEND);
            if ((r_state == ST_SEND) && (w_state_next == ST_SEND) && !w_acc) begin
                r_wdog_cnt <= r_wdog_cnt + 8'd1;
            end else begin
                r_wdog_cnt <= 8'd0;
            end
            r_err_timeout <= w_abort;
        end
    end

    assign bus.err_timeout = r_err_timeout;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.rd_data     = r_rd_data;
    assign bus.cfg_valid   = r_cfg_valid;
    assign bus.cfg_band    = r_cfg_band;
    assign bus.cfg_gain    = r_cfg_gain;
    assign bus.bypass      = r_regs[0][1];
    assign bus.mute        = r_regs[0][2];
    assign bus.busy        = r_busy;
    assign bus.commit_done = r_commit_done;
    assign bus.err_addr    = r_err_addr;

endmodule

// File: tb/tb_eq_cfg_ctrl.sv
// Self-checking bench for eq_cfg_ctrl: register table vectors plus commit/stream sequences.
module tb_eq_cfg_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vecs [13];
    int   gains [10] = '{5, 10, 15, 20, 25, 30, 35, 40, 45, 48};
    int   rx_band [$];
    int   rx_gain [$];

    eq_cfg_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    eq_cfg_ctrl #(
        .NUM_REGS (30),
        .NUM_BANDS(10),
        .ADDR_W   (5),
        .DATA_W   (8),
        .GAIN_MAX (8'd48)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        step();
        check(name, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic pulse_tick();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
    endtask

    // Drives cfg_ready (always, or every 3rd cycle), records accepted bands, checks hold-while-stalled.
    task automatic collect(input int stall_mode, input int budget);
        int         cyc = 0;
        int         stab_bad = 0;
        bit         done = 1'b0;
        bit         pstall = 1'b0;
        logic [3:0] pb = 4'd0;
        logic [7:0] pg = 8'd0;
        rx_band.delete();
        rx_gain.delete();
        while (!done && cyc < budget) begin
            bus.cfg_ready = (stall_mode == 0) ? 1'b1 : ((cyc % 3) == 2);
            if (pstall && (!bus.cfg_valid || bus.cfg_band != pb || bus.cfg_gain != pg)) stab_bad++;
            if (bus.cfg_valid && bus.cfg_ready) begin
                rx_band.push_back(int'(bus.cfg_band));
                rx_gain.push_back(int'(bus.cfg_gain));
            end
            pstall = bus.cfg_valid && !bus.cfg_ready;
            pb     = bus.cfg_band;
            pg     = bus.cfg_gain;
            step();
            cyc++;
            if (bus.commit_done) done = 1'b1;
        end
        bus.cfg_ready = 1'b0;
        check("commit_done_seen", 32'(done), 32'd1);
        check("stall_hold_stable", 32'(stab_bad), 32'd0);
    endtask

    task automatic check_rx(input string name, input int band2_gain);
        check({name, "_count"}, 32'(rx_band.size()), 32'd10);
        for (int i = 0; i < 10 && i < rx_band.size(); i++) begin
            check({name, "_band"}, 32'(rx_band[i]), 32'(i));
            check({name, "_gain"}, 32'(rx_gain[i]), (i == 2) ? 32'(band2_gain) : 32'(gains[i]));
        end
    endtask

    initial begin
        int cnt;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = 5'd0;
        bus.wr_data     = 8'd0;
        bus.rd_addr     = 5'd0;
        bus.sample_tick = 1'b0;
        bus.cfg_ready   = 1'b0;
        rst_n           = 1'b0;

        vecs[0]  = '{5'd1,  8'd5,   8'd5,   1'b0};
        vecs[1]  = '{5'd2,  8'd10,  8'd10,  1'b0};
        vecs[2]  = '{5'd3,  8'd15,  8'd15,  1'b0};
        vecs[3]  = '{5'd4,  8'd20,  8'd20,  1'b0};
        vecs[4]  = '{5'd5,  8'd25,  8'd25,  1'b0};
        vecs[5]  = '{5'd6,  8'd30,  8'd30,  1'b0};
        vecs[6]  = '{5'd7,  8'd35,  8'd35,  1'b0};
        vecs[7]  = '{5'd8,  8'd40,  8'd40,  1'b0};
        vecs[8]  = '{5'd9,  8'd45,  8'd45,  1'b0};
        vecs[9]  = '{5'd10, 8'd50,  8'd48,  1'b0};
        vecs[10] = '{5'd11, 8'd200, 8'd200, 1'b0};
        vecs[11] = '{5'd29, 8'h5A,  8'h5A,  1'b0};
        vecs[12] = '{5'd30, 8'hFF,  8'h00,  1'b1};

        step();
        step();
        check("rst_cfg_valid", 32'(bus.cfg_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_bypass_mute", 32'({bus.bypass, bus.mute}), 32'd0);
        check("rst_pulses", 32'({bus.commit_done, bus.err_addr, bus.err_timeout}), 32'd0);
        rst_n = 1'b1;
        step();

        // Table: write, check err_addr next cycle, read back.
        for (int i = 0; i < 13; i++) begin
            wr(vecs[i].addr, vecs[i].data);
            check("vec_err_addr", 32'(bus.err_addr), 32'(vecs[i].exp_err));
            rd_check("vec_readback", vecs[i].addr, vecs[i].exp_rd);
        end
        rd_check("after_bad_wr_reg29", 5'd29, 8'h5A);
        rd_check("after_bad_wr_reg10", 5'd10, 8'd48);
        rd_check("rd_out_of_range", 5'd31, 8'd0);
        rd_check("reg0_reset", 5'd0, 8'd0);
        check("err_addr_one_pulse", 32'(bus.err_addr), 32'd0);

        // Commit with ready tied high: no valid before tick, then 10 back-to-back bands.
        bus.cfg_ready = 1'b1;
        wr(5'd0, 8'h01);
        check("commit_busy", 32'(bus.busy), 32'd1);
        cnt = 0;
        repeat (20) begin
            if (bus.cfg_valid) cnt++;
            step();
        end
        check("no_valid_before_tick", 32'(cnt), 32'd0);
        pulse_tick();
        for (int b = 0; b < 10; b++) begin
            check("b2b_valid", 32'(bus.cfg_valid), 32'd1);
            check("b2b_band", 32'(bus.cfg_band), 32'(b));
            check("b2b_gain", 32'(bus.cfg_gain), 32'(gains[b]));
            step();
        end
        check("done_pulse", 32'(bus.commit_done), 32'd1);
        check("done_valid_low", 32'(bus.cfg_valid), 32'd0);
        step();
        check("done_single", 32'(bus.commit_done), 32'd0);
        check("idle_busy_low", 32'(bus.busy), 32'd0);
        bus.cfg_ready = 1'b0;
        rd_check("reg0_commit_not_stored", 5'd0, 8'd0);

        // Stalled handshake, ready every 3rd cycle.
        wr(5'd0, 8'h01);
        repeat (3) step();
        pulse_tick();
        collect(1, 200);
        check_rx("stall", 15);
        step();
        check("stall_idle", 32'(bus.busy), 32'd0);

        // Two commits during SEND merge into one follow-up transfer with the new reg3.
        wr(5'd0, 8'h01);
        step();
        pulse_tick();
        wr(5'd0, 8'h01);
        wr(5'd0, 8'h01);
        wr(5'd3, 8'd7);
        check("send_stalled_band", 32'(bus.cfg_band), 32'd0);
        collect(0, 100);
        check_rx("first_xfer", 15);
        step();
        step();
        check("pending_rewait_busy", 32'(bus.busy), 32'd1);
        cnt = 0;
        repeat (5) begin
            if (bus.cfg_valid) cnt++;
            step();
        end
        check("pending_waits_tick", 32'(cnt), 32'd0);
        pulse_tick();
        collect(0, 100);
        check_rx("second_xfer", 7);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            bus.sample_tick = (i % 10 == 0);
            step();
            if (bus.cfg_valid || bus.busy) cnt++;
        end
        bus.sample_tick = 1'b0;
        check("no_third_xfer", 32'(cnt), 32'd0);

        // Control bits in reg0.
        wr(5'd0, 8'h06);
        check("bypass_mute_set", 32'({bus.bypass, bus.mute}), 32'd3);
        check("reg0_no_commit", 32'(bus.busy), 32'd0);
        rd_check("reg0_06", 5'd0, 8'h06);
        wr(5'd0, 8'hF8);
        check("bypass_mute_clr", 32'({bus.bypass, bus.mute}), 32'd0);
        rd_check("reg0_F8", 5'd0, 8'hF8);
        wr(5'd0, 8'h06);

        // Reset in the middle of SEND at band 4.
        bus.cfg_ready = 1'b1;
        wr(5'd0, 8'h01);
        step();
        pulse_tick();
        repeat (4) step();
        check("midsend_band4", 32'(bus.cfg_band), 32'd4);
        check("midsend_valid", 32'(bus.cfg_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check("rst_mid_valid", 32'(bus.cfg_valid), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_bypass", 32'(bus.bypass), 32'd0);
        rst_n = 1'b1;
        bus.cfg_ready = 1'b0;
        rd_check("rst_reg1", 5'd1, 8'd0);
        rd_check("rst_reg10", 5'd10, 8'd0);
        rd_check("rst_reg29", 5'd29, 8'd0);
        rd_check("rst_reg0", 5'd0, 8'd0);
        check("rst_stays_idle", 32'(bus.busy), 32'd0);

        // Ready held low for a long stall.
        wr(5'd0, 8'h01);
        step();
        pulse_tick();
`ifdef EQ_CFG_TIMEOUT_EN
        cnt = 0;
        while (!bus.err_timeout && cnt < 400) begin
            step();
            cnt++;
        end
        check("timeout_cycles", 32'(cnt), 32'd255);
        check("timeout_valid_low", 32'(bus.cfg_valid), 32'd0);
        check("timeout_no_done", 32'(bus.commit_done), 32'd0);
        check("timeout_idle", 32'(bus.busy), 32'd0);
        step();
        check("timeout_single", 32'(bus.err_timeout), 32'd0);
`else
        cnt = 0;
        repeat (300) begin
            if (bus.err_timeout || !bus.cfg_valid) cnt++;
            step();
        end
        check("no_timeout_holds", 32'(cnt), 32'd0);
        check("no_timeout_band", 32'(bus.cfg_band), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
